// File: rtl/output_collector.sv
// Output-face collector: deskews the column-staggered partial-sum stream into whole
// rows, buffers them in a row FIFO and drains one row per valid/ready beat.
module output_collector #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 32,
    parameter int A_ROWS     = 8,
    parameter int DEPTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic                                 start,
    input  logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  of_data,
    output logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  o_data,
    output logic                                 o_valid,
    input  logic                                 o_ready,
    output logic                                 o_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_overflow,
    output logic [1:0]                           dbg_state
);

    // Handshake: a row transfers on any rising edge where o_valid & o_ready are both
    // high; while o_valid=1 and o_ready=0, o_data/o_last hold the same FIFO head.

    localparam int W    = SYS_COLS * P_BITWIDTH;
    localparam int CW   = $clog2(A_ROWS + SYS_COLS);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   PUSH_CNT = CW'(SYS_COLS - 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(A_ROWS + SYS_COLS - 2);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Column c needs SYS_COLS-1-c stages so every column lines up with the last one.
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0] row_aligned;

    for (genvar c = 0; c < SYS_COLS; c++) begin : g_col
        localparam int D = SYS_COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign row_aligned[c] = of_data[c];
        end else begin : g_dl
            logic [P_BITWIDTH-1:0] dl_q [D];
            logic [P_BITWIDTH-1:0] dl_d [D];

            always_comb begin
                dl_d[0] = of_data[c];
                for (int k = 1; k < D; k++) begin
                    dl_d[k] = dl_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                dl_q <= dl_d;
            end

            assign row_aligned[c] = dl_q[D-1];
        end
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [W:0]      mem_q [DEPTH];
    logic [W:0]      mem_d [DEPTH];

    logic       push, pop, full, wr_en;
    logic [W:0] head;

    assign head    = mem_q[rd_ptr_q];
    assign o_valid = (count_q != '0);
    assign o_data  = o_valid ? head[W-1:0] : '0;
    assign o_last  = o_valid & head[W];
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_q;
    assign dbg_state    = state_q;

    assign full  = (count_q == FULL_CNT);
    assign push  = (state_q == CAPTURE) && (cnt_q >= PUSH_CNT);
    assign pop   = o_valid && o_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        // cnt counts cycles since start, so the start cycle itself is cnt=0.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    cnt_d   = CW'(1);
                    busy_d  = 1'b1;
                end
            end
            CAPTURE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && o_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            mem_d[wr_ptr_q] = {(cnt_q == LAST_CNT), row_aligned};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CNTW'(1);
        end
        if (push && full && !pop) begin
            err_d = 1'b1;
        end

        if (clr) begin
            state_d  = IDLE;
            cnt_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Row storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: a DEPTH=16 instance checked by a row scoreboard and a
// DEPTH=4 instance sharing the same inputs for the overflow case.
module tb_output_collector;
    localparam int SC = 4;
    localparam int PB = 32;
    localparam int AR = 8;
    localparam int W  = SC * PB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic start = 1'b0;
    logic o_ready = 1'b0;
    logic [SC-1:0][PB-1:0] of_data = '0;

    logic [SC-1:0][PB-1:0] o_data, o_data4;
    logic o_valid, o_last, busy, done, err_overflow;
    logic o_valid4, o_last4, busy4, done4, err_overflow4;
    logic [1:0] dbg_state, dbg_state4;

    output_collector #(.SYS_COLS(SC), .P_BITWIDTH(PB), .A_ROWS(AR), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .of_data(of_data),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
        .busy(busy), .done(done), .err_overflow(err_overflow), .dbg_state(dbg_state)
    );

    output_collector #(.SYS_COLS(SC), .P_BITWIDTH(PB), .A_ROWS(AR), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .of_data(of_data),
        .o_data(o_data4), .o_valid(o_valid4), .o_ready(o_ready), .o_last(o_last4),
        .busy(busy4), .done(done4), .err_overflow(err_overflow4), .dbg_state(dbg_state4)
    );

    // clock / reset timing
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W:0] exp_q[$];
    logic [W:0] exp4_q[$];
    int n_checks = 0, n_errors = 0;
    int rows_seen = 0, lasts_seen = 0, dones_seen = 0;
    int rows4 = 0, dones4 = 0;
    bit mon4_en = 1'b0;

    bit start_req = 1'b0, start_real = 1'b0;
    int tile_t0 = -1000, tile_base = 0;

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] mk_row(input int base, input int r);
        logic [SC-1:0][PB-1:0] d;
        for (int c = 0; c < SC; c++) d[c] = PB'(base + 100 * r + c);
        return {(r == AR - 1), d};
    endfunction

    // driver: one call = one cycle; inputs change 1ns after the rising edge
    task automatic tick();
        int r;
        @(posedge clk);
        #1;
        start = start_req;
        if (start_req && start_real) begin
            tile_t0 = cyc;
            for (int k = 0; k < AR; k++) exp_q.push_back(mk_row(tile_base, k));
        end
        start_req  = 1'b0;
        start_real = 1'b0;
        for (int c = 0; c < SC; c++) begin
            r = cyc - tile_t0 - c;
            of_data[c] = (r >= 0 && r < AR) ? PB'(tile_base + 100 * r + c) : PB'($urandom());
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic go(input int base);
        tile_base  = base;
        start_req  = 1'b1;
        start_real = 1'b1;
        tick();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        exp4_q.delete();
    endtask

    // monitor: every accepted row is compared against the head of the expected queue
    always @(negedge clk) begin
        if (rst) begin
            if (o_valid && o_ready) begin
                rows_seen++;
                if (o_last) lasts_seen++;
                chk("sb_has_entry", W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_row", {o_last, o_data}, exp_q.pop_front());
            end
            if (done) dones_seen++;
            if (mon4_en && o_valid4 && o_ready) begin
                rows4++;
                chk("sb4_has_entry", W'(exp4_q.size() != 0), 1);
                if (exp4_q.size() != 0) chk("sb4_row", {o_last4, o_data4}, exp4_q.pop_front());
            end
            if (mon4_en && done4) dones4++;
        end
    end

    initial begin
        int r0, d0, l0, n;
        bit found;
        logic [W:0] row0;

        // reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_last", o_last, 0);
        chk("rst_data", o_data, 0);
        chk("rst_state", dbg_state, 0);
        ticks(3);
        rst = 1'b1;
        ticks(2);

        // basic deskew, o_ready held high
        o_ready = 1'b1;
        r0 = rows_seen;
        go(0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            sample();
            chk($sformatf("t1_valid@%0d", k), o_valid, (k >= 4 && k <= 11));
            chk($sformatf("t1_busy@%0d", k), busy, (k <= 11));
            chk($sformatf("t1_done@%0d", k), done, (k == 12));
            if (k == 4) chk("t1_first_row", o_data, {32'd3, 32'd2, 32'd1, 32'd0});
        end
        chk("t1_rows", rows_seen - r0, 8);
        chk("t1_sb_empty", exp_q.size(), 0);

        // backpressure until T+20
        tick();
        o_ready = 1'b0;
        ticks(2);
        r0 = rows_seen;
        row0 = mk_row(1000, 0);
        go(1000);
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (k == 20) o_ready = 1'b1;
            sample();
            if (k >= 4 && k <= 19) begin
                chk($sformatf("t2_hold_valid@%0d", k), o_valid, 1);
                chk($sformatf("t2_hold_data@%0d", k), o_data, row0[W-1:0]);
            end
            if (k >= 12) chk($sformatf("t2_done@%0d", k), done, (k == 28));
        end
        chk("t2_rows", rows_seen - r0, 8);
        chk("t2_sb_empty", exp_q.size(), 0);

        // overflow on the DEPTH=4 instance
        tick();
        do_clr();
        o_ready = 1'b0;
        rows4 = 0;
        dones4 = 0;
        for (int k = 0; k < 4; k++) exp4_q.push_back(mk_row(2000, k));
        mon4_en = 1'b1;
        go(2000);
        for (int k = 1; k <= 14; k++) begin
            tick();
            sample();
            if (k == 6) chk("t3_err_early", err_overflow4, 0);
            if (k >= 8) chk($sformatf("t3_err@%0d", k), err_overflow4, 1);
            chk($sformatf("t3_valid4@%0d", k), o_valid4, (k >= 4));
        end
        tick();
        o_ready = 1'b1;
        ticks(12);
        sample();
        chk("t3_rows_kept", rows4, 4);
        chk("t3_sb4_empty", exp4_q.size(), 0);
        chk("t3_no_done", dones4, 0);
        chk("t3_busy_stuck", busy4, 1);
        chk("t3_state_drain", dbg_state4, 2);
        chk("t3_err_sticky", err_overflow4, 1);
        do_clr();
        mon4_en = 1'b0;
        sample();
        chk("t3_clr_valid4", o_valid4, 0);
        chk("t3_clr_err4", err_overflow4, 0);
        chk("t3_clr_busy4", busy4, 0);
        chk("t3_clr_state4", dbg_state4, 0);
        chk("t3_clr_valid", o_valid, 0);

        // start while busy is ignored
        tick();
        o_ready = 1'b1;
        r0 = rows_seen;
        d0 = dones_seen;
        go(3000);
        ticks(2);
        start_req = 1'b1;
        start_real = 1'b0;
        tick();
        ticks(16);
        sample();
        chk("t4_rows", rows_seen - r0, 8);
        chk("t4_dones", dones_seen - d0, 1);
        chk("t4_sb_empty", exp_q.size(), 0);

        // back-to-back tiles
        r0 = rows_seen;
        d0 = dones_seen;
        l0 = lasts_seen;
        go(4000);
        n = 0;
        found = 1'b0;
        while (n < 40 && !found) begin
            tick();
            sample();
            if (done) found = 1'b1;
            n++;
        end
        chk("t5_first_done_seen", found, 1);
        go(5000);
        ticks(16);
        sample();
        chk("t5_rows", rows_seen - r0, 16);
        chk("t5_lasts", lasts_seen - l0, 2);
        chk("t5_dones", dones_seen - d0, 2);
        chk("t5_sb_empty", exp_q.size(), 0);

        // async reset mid-tile
        go(6000);
        ticks(5);
        #2;
        chk("t6_pre_valid", o_valid, 1);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_state", dbg_state, 0);
        exp_q.delete();
        exp4_q.delete();
        tile_t0 = -1000;
        ticks(2);
        rst = 1'b1;
        ticks(2);
        r0 = rows_seen;
        d0 = dones_seen;
        go(7000);
        ticks(16);
        sample();
        chk("t6_rows", rows_seen - r0, 8);
        chk("t6_dones", dones_seen - d0, 1);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
